// File: rtl/skewed_mem_arr.sv
// Banked row memories with a tile-read sequencer feeding the systolic array.
// Each row streams len words from base, optionally skewed one cycle per row.
module skewed_mem_arr #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    wr_en,
  input  logic [N*AW-1:0] wr_addr,
  input  logic [N*DW-1:0] wr_data,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW:0]     len,
  input  logic            skew_en,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    rd_valid,
  output logic [N*DW-1:0] rd_data
);

  localparam int TW = $clog2(DEPTH + N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] t;
  logic [TW-1:0] t_last;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic          skew_q;

  logic [N-1:0]  rd_issue;
  logic [TW-1:0] rel     [N];
  logic [AW-1:0] rd_addr [N];

  logic [DW-1:0] mem [N][DEPTH];

  assign busy = (state != IDLE);

  always_comb begin
    t_last = TW'(len_q) - TW'(1)
           + (skew_q ? TW'(N - 1) : TW'(0));
  end

  // rel is the row's word index; underflow is masked by the t >= off test
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rel[i]      = t - (skew_q ? TW'(i) : TW'(0));
      rd_issue[i] = (state == RUN)
                  && (t >= (skew_q ? TW'(i) : TW'(0)))
                  && (rel[i] < TW'(len_q));
      rd_addr[i]  = base_q + rel[i][AW-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (len == '0) ? DRAIN : RUN;
      end
      RUN: begin
        if (t == t_last)
          state_nxt = DRAIN;
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t      <= '0;
      base_q <= '0;
      len_q  <= '0;
      skew_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == DRAIN);
      if (state == IDLE && start) begin
        t      <= '0;
        base_q <= base_addr;
        len_q  <= len;
        skew_q <= skew_en;
      end else if (state == RUN) begin
        t <= t + TW'(1);
      end
    end
  end

  // Contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (wr_en[i])
        mem[i][wr_addr[i*AW +: AW]] <= wr_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        rd_valid[i] <= rd_issue[i];
        rd_data[i*DW +: DW] <= rd_issue[i]
                             ? mem[i][rd_addr[i]]
                             : '0;
      end
    end
  end

endmodule

// File: tb/tb_skewed_mem_arr.sv
// Directed and random tile reads of skewed_mem_arr against a
// word-level model of row contents and per-row delivery windows.
module tb_skewed_mem_arr;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    wr_en;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     len;
  logic            skew_en;
  logic            busy;
  logic            done;
  logic [N-1:0]    rd_valid;
  logic [N*DW-1:0] rd_data;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [N][DEPTH];

  always #5 clk = ~clk;

  skewed_mem_arr #(
    .N(N), .DW(DW), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .skew_en(skew_en),
    .busy(busy),
    .done(done),
    .rd_valid(rd_valid),
    .rd_data(rd_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_row(input int row, input int addr,
                           input logic [DW-1:0] data);
    wr_en = '0;
    wr_en[row] = 1'b1;
    wr_addr[row*AW +: AW] = AW'(addr);
    wr_data[row*DW +: DW] = data;
    @(posedge clk);
    #1;
    wr_en = '0;
    model[row][addr] = data;
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = '1;
      for (int i = 0; i < N; i++) begin
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*DW +: DW] = DW'($urandom);
        model[i][a] = wr_data[i*DW +: DW];
      end
      @(posedge clk);
      #1;
    end
    wr_en = '0;
  endtask

  // Expected: row i delivers word k of the tile in cycle off_i+k+1
  // after the start edge; done follows the last step by two cycles.
  task automatic run_tile(input string nm, input int base,
                          input int ln, input bit skw,
                          input bit poke, input bit col,
                          input int col_step, input int col_addr,
                          input logic [DW-1:0] col_data);
    int last;
    int k;
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    bit wrote;
    last = (ln == 0) ? 1 : ln + (skw ? N - 1 : 0) + 1;
    start = 1'b1;
    base_addr = AW'(base);
    len = (AW+1)'(ln);
    skew_en = skw;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    len = (AW+1)'($urandom);
    skew_en = 1'($urandom);
    check({nm, ".busy0"}, 32'(busy), 32'd1);
    check({nm, ".valid0"}, 32'(rd_valid), 32'd0);
    for (int c = 1; c <= last; c++) begin
      ev = '0;
      ed = '0;
      for (int i = 0; i < N; i++) begin
        k = c - (skw ? i : 0) - 1;
        if (k >= 0 && k < ln) begin
          ev[i] = 1'b1;
          ed[i*DW +: DW] = model[i][(base + k) % DEPTH];
        end
      end
      if (poke && c == 2)
        start = 1'b1;
      wrote = col && (c == col_step + 1);
      if (wrote) begin
        wr_en = '0;
        wr_en[0] = 1'b1;
        wr_addr[0 +: AW] = AW'(col_addr);
        wr_data[0 +: DW] = col_data;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = '0;
      if (wrote)
        model[0][col_addr] = col_data;
      check($sformatf("%s.busy%0d", nm, c), 32'(busy),
            32'(c < last));
      check($sformatf("%s.done%0d", nm, c), 32'(done),
            32'(c == last));
      check($sformatf("%s.valid%0d", nm, c), 32'(rd_valid),
            32'(ev));
      check($sformatf("%s.data%0d", nm, c), 32'(rd_data),
            32'(ed));
    end
    @(posedge clk);
    #1;
    check({nm, ".done_end"}, 32'(done), 32'd0);
    check({nm, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    skew_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.valid", 32'(rd_valid), 32'd0);
    check("rst.data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    fill_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++)
        write_row(i, j, DW'(16 * i + j));

    run_tile("t1", 0, 3, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    run_tile("t2", 0, 3, 1'b1, 1'b0, 1'b0, 0, 0, '0);

    for (int i = 0; i < N; i++) begin
      write_row(i, 254, 8'hAA);
      write_row(i, 255, 8'hBB);
      write_row(i, 0, 8'hCC);
      write_row(i, 1, 8'hDD);
    end
    run_tile("t3", 254, 4, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    run_tile("t3s", 254, 4, 1'b1, 1'b0, 1'b0, 0, 0, '0);

    run_tile("t4", 9, 0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    run_tile("t4s", 9, 0, 1'b1, 1'b0, 1'b0, 0, 0, '0);

    for (int i = 0; i < N; i++)
      write_row(i, 0, DW'(16 * i));
    run_tile("t5", 0, 3, 1'b0, 1'b1, 1'b0, 0, 0, '0);

    start = 1'b1;
    base_addr = '0;
    len = 9'd3;
    skew_en = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid.valid", 32'(rd_valid), 32'd0);
    check("rst_mid.data", 32'(rd_data), 32'd0);
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("rst_mid.nodone", 32'(done), 32'd0);
      check("rst_mid.idle", 32'(busy), 32'd0);
    end
    run_tile("t5r", 0, 3, 1'b0, 1'b0, 1'b0, 0, 0, '0);

    run_tile("t6", 10, 5, 1'b0, 1'b0, 1'b1, 2, 12, 8'h5A);
    run_tile("t6r", 12, 1, 1'b0, 1'b0, 1'b0, 0, 0, '0);

    run_tile("full", int'($urandom_range(0, DEPTH - 1)), DEPTH,
             1'b1, 1'b0, 1'b0, 0, 0, '0);
    for (int r = 0; r < 6; r++)
      run_tile("rnd", int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(1, 20)), 1'($urandom),
               1'($urandom), 1'b0, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
